prf_multiport: RTL and testbench
================================

// Module: prf_multiport
// PURPOSE
//  Parametrised physical register file for the R10K-style OoO core: NUM_PRN entries of {valid, value}.
//  Generalises the fixed-port PRF in three ways: read, write and invalidate port counts are independent;
//  same-cycle write->read bypass is optional; the count of valid entries is maintained incrementally.
//  Sits between issue/operand read (read ports), complete/CDB (write ports) and dispatch (invalidate
//  ports, which mark a newly allocated destination PRN not ready).
// PARAMETERS
//  NUM_PRN  `PHYS_REG_SZ_R10K  number of physical registers; PRN 0 is hard-wired zero
//  DATA_W   32                 width of DATA
//  NUM_RD   2*`N               read ports (two source operands per dispatched instruction)
//  NUM_WR   `N                 write ports
//  NUM_INV  `N                 invalidate ports
//  BYPASS   1                  1: reads see same-cycle writes; 0: reads see registered state only
// PORTS
//  clock         in   1                     system clock; all state updates on posedge
//  reset         in   1                     synchronous, active-high
//  read_prn      in   NUM_RD x PRN          read addresses
//  output_value  out  NUM_RD x PRF_ENTRY    {valid, value} for each read_prn
//  write_data    in   NUM_WR x PRF_WRITE    {value, prn}; prn==0 means no write
//  prn_invalid   in   NUM_INV x PRN         PRNs to mark not-ready; 0 means no-op
//  entries_out   out  NUM_PRN x PRF_ENTRY   registered full table, for debug and verification
//  counter       out  PRN                   number of valid entries among PRN 1..NUM_PRN-1
// BEHAVIOUR
//  Reset (sync, active-high): entry 0 = {1, 0}; entries 1..NUM_PRN-1 have valid=0 and their value is
//   don't-care; counter = 0. Reset has priority over every write and invalidate in that cycle.
//  Write: write_data[i].prn = p != 0 -> at the next posedge entry[p] = {1, value}. Latency 1 cycle.
//  Invalidate: prn_invalid[j] = p != 0 -> at the next posedge entry[p].valid = 0; value is kept.
//  PRN 0: writes and invalidates of PRN 0 are ignored; entry 0 always reads {1, 0}.
//  Conflicts in one cycle:
//   - several writes to the same p: the highest port index wins
//   - write and invalidate to the same p: the write wins, so the entry ends valid
//   - several invalidates to the same p: the same as one invalidate
//  Read (combinational, zero latency):
//   - BYPASS=1: if any write port targets read_prn[k] != 0 this cycle, output_value[k] = {1, that
//     value} (highest port wins); otherwise the registered entry
//   - BYPASS=0: always the registered entry
//   - invalidates never bypass; they take effect only from the next cycle
//   - outputs are X-free whenever inputs are known
//  counter:
//   - counter_next = counter + (#distinct p that go 0->1) - (#distinct p that go 1->0)
//   - it must always equal popcount(entry[NUM_PRN-1:1].valid)
//   - it never counts entry 0, so the maximum is NUM_PRN-1, which fits in PRN
//   - rewriting an already-valid p does not increment it; invalidating an invalid p does not
//     decrement it
//  entries_out is the registered state; it updates on the same edge as counter.
//  Writes and invalidates may be issued mid-operation in every cycle; there is no stall or handshake.
//  No full or empty condition exists: all entries remain addressable at all times.
// STRUCTURE
//  Shared package (sys_defs.svh): PRN, DATA, PRF_ENTRY {valid, value}, PRF_WRITE {value, prn},
//   `N, `PHYS_REG_SZ_R10K.
//  Sub-module prf_update_merge (combinational), one per table:
//   - resolves, per entry, write enable, write value, invalidate and final next-valid
//   - produces the inc and dec counts used for counter
//  Top level holds the entry registers, the counter register and the read/bypass muxes.
//  Use generate on BYPASS for the muxes.
// TESTING
//  1 Reset: hold reset for 2 cycles, then release -> entry0 = {1, 0}, all others invalid, counter = 0;
//    a read of PRN 0 returns {1, 0}.
//  2 Fill: write PRNs 1..NUM_PRN-1 over successive cycles, NUM_WR per cycle, with random values ->
//    entries_out matches a scoreboard each cycle; final counter = NUM_PRN-1; a write to PRN 0 is ignored.
//  3 Invalidate: from the full table, invalidate PRN 5 on two ports plus PRN 0 in one cycle -> next
//    cycle entry5 is invalid, entry0 is still valid, counter = NUM_PRN-2.
//  4 Conflict: in one cycle, write PRN 7 = 0xAAAA on port 0, 0x5555 on port NUM_WR-1, and invalidate
//    PRN 7 -> next cycle entry7 = {1, 0x5555}; counter changes by +1 only if PRN 7 was invalid before.
//  5 Bypass: with BYPASS=1, write PRN 9 = 0xDEADBEEF while read_prn[0] = 9 -> output_value[0] =
//    {1, 0xDEADBEEF} in the same cycle. With BYPASS=0 it shows the old entry that cycle, the new one next.
//  6 Random soak: 10k cycles of random writes, invalidates and reads on all ports ->
//    counter == popcount(valid[NUM_PRN-1:1]) and reads match the scoreboard every cycle;
//    run with NUM_RD = 4, 6 and NUM_WR = 1, 3.

Source files
------------

// File: rtl/prf_multiport_pkg.sv
// ============================================================================
// prf_multiport_pkg
// Shared sizes and types for the R10K-style physical register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package prf_multiport_pkg;

    // Superscalar width and default physical register count.
    localparam int N                = 3;
    localparam int PHYS_REG_SZ_R10K = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int PRN_W_DEF        = $clog2(PHYS_REG_SZ_R10K);

    typedef logic [PRN_W_DEF-1:0]  PRN;
    typedef logic [DATA_W_DEF-1:0] DATA;

    typedef struct packed {
        logic valid;
        DATA  value;
    } PRF_ENTRY;

    typedef struct packed {
        DATA value;
        PRN  prn;
    } PRF_WRITE;

    // Address width for a table of n entries (at least one bit).
    function automatic int prn_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prf_multiport_merge.sv
// ============================================================================
// prf_update_merge
// Per-entry resolution of one cycle's writes and invalidates for entries
// 1..NUM_PRN-1: write enable/value (highest write port wins), invalidate,
// next valid bit, and the count of entries turning valid / invalid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prf_update_merge #(
    parameter int NUM_PRN = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_WR  = 3,
    parameter int NUM_INV = 3,
    parameter int PRN_W   = 5
) (
    input  logic [NUM_PRN-1:1]                     cur_valid_i,
    input  logic [NUM_WR-1:0][DATA_W+PRN_W-1:0]    write_data_i,
    input  logic [NUM_INV-1:0][PRN_W-1:0]          prn_invalid_i,
    output logic [NUM_PRN-1:1]                     wr_en_o,
    output logic [NUM_PRN-1:1][DATA_W-1:0]         wr_val_o,
    output logic [NUM_PRN-1:1]                     next_valid_o,
    output logic [PRN_W-1:0]                       inc_o,
    output logic [PRN_W-1:0]                       dec_o
);

    localparam logic [PRN_W-1:0] ONE = PRN_W'(1);

    logic [NUM_PRN-1:1] inv_hit;

    // Decode write and invalidate ports per entry; later write ports override earlier ones.
    always_comb begin
        wr_en_o  = '0;
        wr_val_o = '0;
        inv_hit  = '0;
        for (int p = 1; p < NUM_PRN; p++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (write_data_i[i][PRN_W-1:0] == PRN_W'(p)) begin
                    wr_en_o[p]  = 1'b1;
                    wr_val_o[p] = write_data_i[i][DATA_W+PRN_W-1:PRN_W];
                end
            end
            for (int j = 0; j < NUM_INV; j++) begin
                if (prn_invalid_i[j] == PRN_W'(p)) begin
                    inv_hit[p] = 1'b1;
                end
            end
        end
    end

    // Next valid bit (write beats invalidate) and the 0->1 / 1->0 transition counts.
    always_comb begin
        next_valid_o = '0;
        inc_o        = '0;
        dec_o        = '0;
        for (int p = 1; p < NUM_PRN; p++) begin
            next_valid_o[p] = wr_en_o[p] | (cur_valid_i[p] & ~inv_hit[p]);
            if (next_valid_o[p] && !cur_valid_i[p]) begin
                inc_o = inc_o + ONE;
            end
            if (!next_valid_o[p] && cur_valid_i[p]) begin
                dec_o = dec_o + ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prf_multiport.sv
// ============================================================================
// prf_multiport
// Multi-ported physical register file of {valid, value} entries. PRN 0 is
// hard-wired to {1, 0}. Independent read/write/invalidate port counts,
// optional same-cycle write->read bypass, incrementally kept valid count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prf_multiport
    import prf_multiport_pkg::*;
#(
    parameter int NUM_PRN  = PHYS_REG_SZ_R10K,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_RD   = 2 * N,
    parameter int NUM_WR   = N,
    parameter int NUM_INV  = N,
    parameter int BYPASS   = 1,
    localparam int PRN_W   = prn_width(NUM_PRN)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_RD-1:0][PRN_W-1:0]        read_prn,
    output logic [NUM_RD-1:0][DATA_W:0]         output_value,
    input  logic [NUM_WR-1:0][DATA_W+PRN_W-1:0] write_data,
    input  logic [NUM_INV-1:0][PRN_W-1:0]       prn_invalid,
    output logic [NUM_PRN-1:0][DATA_W:0]        entries_out,
    output logic [PRN_W-1:0]                    counter
);

    // Entry 0 is constant, so only entries 1..NUM_PRN-1 carry state.
    logic [NUM_PRN-1:1]             valid_q,  valid_d;
    logic [NUM_PRN-1:1][DATA_W-1:0] value_q,  value_d;
    logic [PRN_W-1:0]               counter_q, counter_d;

    logic [NUM_PRN-1:1]             wr_en;
    logic [NUM_PRN-1:1][DATA_W-1:0] wr_val;
    logic [PRN_W-1:0]               inc_cnt;
    logic [PRN_W-1:0]               dec_cnt;

    prf_update_merge #(
        .NUM_PRN (NUM_PRN),
        .DATA_W  (DATA_W),
        .NUM_WR  (NUM_WR),
        .NUM_INV (NUM_INV),
        .PRN_W   (PRN_W)
    ) u_merge (
        .cur_valid_i   (valid_q),
        .write_data_i  (write_data),
        .prn_invalid_i (prn_invalid),
        .wr_en_o       (wr_en),
        .wr_val_o      (wr_val),
        .next_valid_o  (valid_d),
        .inc_o         (inc_cnt),
        .dec_o         (dec_cnt)
    );

    // Next values: written entries take the winning write value, others hold.
    always_comb begin
        value_d = value_q;
        for (int p = 1; p < NUM_PRN; p++) begin
            if (wr_en[p]) begin
                value_d[p] = wr_val[p];
            end
        end
        counter_d = counter_q + inc_cnt - dec_cnt;
    end

    // Table and counter registers; reset overrides any same-cycle update.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= '0;
            value_q   <= '0;
            counter_q <= '0;
        end else begin
            valid_q   <= valid_d;
            value_q   <= value_d;
            counter_q <= counter_d;
        end
    end

    // Registered table view including the constant zero entry.
    always_comb begin
        entries_out    = '0;
        entries_out[0] = {1'b1, {DATA_W{1'b0}}};
        for (int p = 1; p < NUM_PRN; p++) begin
            entries_out[p] = {valid_q[p], value_q[p]};
        end
    end

    assign counter = counter_q;

    generate
        if (BYPASS != 0) begin : g_bypass
            // Read mux over the registered table, then same-cycle writes override (highest port last).
            always_comb begin
                output_value = '0;
                for (int k = 0; k < NUM_RD; k++) begin
                    for (int p = 0; p < NUM_PRN; p++) begin
                        if (read_prn[k] == PRN_W'(p)) begin
                            output_value[k] = entries_out[p];
                        end
                    end
                    for (int i = 0; i < NUM_WR; i++) begin
                        if ((read_prn[k] != '0) && (write_data[i][PRN_W-1:0] == read_prn[k])) begin
                            output_value[k] = {1'b1, write_data[i][DATA_W+PRN_W-1:PRN_W]};
                        end
                    end
                end
            end
        end else begin : g_registered
            // Read mux over the registered table only.
            always_comb begin
                output_value = '0;
                for (int k = 0; k < NUM_RD; k++) begin
                    for (int p = 0; p < NUM_PRN; p++) begin
                        if (read_prn[k] == PRN_W'(p)) begin
                            output_value[k] = entries_out[p];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_prf_multiport.sv
// ============================================================================
// tb_prf_multiport
// Bench for prf_multiport: a bypassing and a non-bypassing instance share the
// same stimulus; a reference table model produces expected registered state
// into a queue that a monitor pops after every clock edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prf_multiport;

    localparam int NUM_PRN = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_RD  = 6;
    localparam int NUM_WR  = 3;
    localparam int NUM_INV = 3;
    localparam int PRN_W   = 5;
    localparam int WW      = DATA_W + PRN_W;

    typedef struct packed {
        logic [NUM_PRN-1:0]             valid;
        logic [NUM_PRN-1:0]             known;
        logic [NUM_PRN-1:0][DATA_W-1:0] value;
        logic [PRN_W-1:0]               cnt;
    } exp_t;

    logic                             clock = 1'b0;
    logic                             reset = 1'b1;
    logic [NUM_RD-1:0][PRN_W-1:0]     read_prn    = '0;
    logic [NUM_WR-1:0][WW-1:0]        write_data  = '0;
    logic [NUM_INV-1:0][PRN_W-1:0]    prn_invalid = '0;
    logic [NUM_RD-1:0][DATA_W:0]      output_value, ov_nb;
    logic [NUM_PRN-1:0][DATA_W:0]     entries_out, ent_nb;
    logic [PRN_W-1:0]                 counter, cnt_nb;

    // Reference model of the registered table.
    logic [NUM_PRN-1:0]               m_valid;
    logic [NUM_PRN-1:0]               m_known;
    logic [NUM_PRN-1:0][DATA_W-1:0]   m_value;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    prf_multiport #(
        .NUM_PRN (NUM_PRN), .DATA_W (DATA_W), .NUM_RD (NUM_RD),
        .NUM_WR  (NUM_WR),  .NUM_INV (NUM_INV), .BYPASS (1)
    ) dut (
        .clock (clock), .reset (reset), .read_prn (read_prn),
        .output_value (output_value), .write_data (write_data),
        .prn_invalid (prn_invalid), .entries_out (entries_out), .counter (counter)
    );

    prf_multiport #(
        .NUM_PRN (NUM_PRN), .DATA_W (DATA_W), .NUM_RD (NUM_RD),
        .NUM_WR  (NUM_WR),  .NUM_INV (NUM_INV), .BYPASS (0)
    ) dut_nb (
        .clock (clock), .reset (reset), .read_prn (read_prn),
        .output_value (ov_nb), .write_data (write_data),
        .prn_invalid (prn_invalid), .entries_out (ent_nb), .counter (cnt_nb)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [WW-1:0] mkw(input logic [DATA_W-1:0] v, input int p);
        return {v, p[PRN_W-1:0]};
    endfunction

    function automatic logic [DATA_W:0] exp_read(input logic [PRN_W-1:0] p, input bit byp);
        logic [DATA_W:0] r;
        if (p == '0) return {1'b1, {DATA_W{1'b0}}};
        r = {m_valid[p], m_value[p]};
        if (byp)
            for (int i = 0; i < NUM_WR; i++)
                if (write_data[i][PRN_W-1:0] == p) r = {1'b1, write_data[i][WW-1:PRN_W]};
        return r;
    endfunction

    function automatic bit exp_known(input logic [PRN_W-1:0] p, input bit byp);
        bit k;
        k = m_known[p];
        if (byp && p != '0)
            for (int i = 0; i < NUM_WR; i++)
                if (write_data[i][PRN_W-1:0] == p) k = 1'b1;
        return k;
    endfunction

    task automatic clear_inputs();
        write_data  = '0;
        prn_invalid = '0;
        read_prn    = '0;
    endtask

    // Apply the current inputs to the model and queue the post-edge expectation.
    task automatic advance();
        exp_t e;
        int c;
        logic wr, iv;
        logic [DATA_W-1:0] wv;
        if (reset) begin
            m_valid = '0; m_valid[0] = 1'b1;
            m_known = '0; m_known[0] = 1'b1;
            m_value = '0;
        end else begin
            for (int p = 1; p < NUM_PRN; p++) begin
                wr = 1'b0; iv = 1'b0; wv = '0;
                for (int i = 0; i < NUM_WR; i++)
                    if (write_data[i][PRN_W-1:0] == p[PRN_W-1:0]) begin
                        wr = 1'b1;
                        wv = write_data[i][WW-1:PRN_W];
                    end
                for (int j = 0; j < NUM_INV; j++)
                    if (prn_invalid[j] == p[PRN_W-1:0]) iv = 1'b1;
                if (wr) begin
                    m_valid[p] = 1'b1; m_value[p] = wv; m_known[p] = 1'b1;
                end else if (iv) begin
                    m_valid[p] = 1'b0;
                end
            end
        end
        c = 0;
        for (int p = 1; p < NUM_PRN; p++) c += int'(m_valid[p]);
        e.valid = m_valid;
        e.known = m_known;
        e.value = m_value;
        e.cnt   = c[PRN_W-1:0];
        sb_q.push_back(e);
    endtask

    // Monitor: after each edge, compare both instances' registered state against the queue head.
    initial begin
        logic [NUM_PRN-1:0] v, vn;
        bit mism;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                for (int p = 0; p < NUM_PRN; p++) begin
                    v[p]  = entries_out[p][DATA_W];
                    vn[p] = ent_nb[p][DATA_W];
                end
                total++;
                if (counter !== mon_e.cnt) begin
                    bad++;
                    $display("FAIL sb_counter t=%0t got=%0d exp=%0d", $time, counter, mon_e.cnt);
                end
                total++;
                if (cnt_nb !== mon_e.cnt) begin
                    bad++;
                    $display("FAIL sb_counter_nb t=%0t got=%0d exp=%0d", $time, cnt_nb, mon_e.cnt);
                end
                total++;
                if (v !== mon_e.valid || vn !== mon_e.valid) begin
                    bad++;
                    $display("FAIL sb_valid t=%0t got=%h nb=%h exp=%h", $time, v, vn, mon_e.valid);
                end
                mism = 1'b0;
                for (int p = 0; p < NUM_PRN; p++)
                    if (mon_e.known[p] && (entries_out[p][DATA_W-1:0] !== mon_e.value[p] ||
                                           ent_nb[p][DATA_W-1:0] !== mon_e.value[p])) begin
                        if (!mism)
                            $display("FAIL sb_value t=%0t prn=%0d got=%h nb=%h exp=%h", $time, p,
                                     entries_out[p][DATA_W-1:0], ent_nb[p][DATA_W-1:0], mon_e.value[p]);
                        mism = 1'b1;
                    end
                total++;
                if (mism) bad++;
            end
        end
    end

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        write_data[0] = mkw(32'h1234_5678, 3);
        prn_invalid[0] = 5'd4;
        #1; advance();
        @(negedge clock);
        write_data[1] = mkw(32'h0BAD_0BAD, 6);
        #1; advance();
        @(negedge clock);
        reset = 1'b0;
        clear_inputs();
        #1;
        total++;
        if (output_value[0] !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL reset_read0 got=%h exp=%h", output_value[0], {1'b1, 32'h0});
        end
        total++;
        if (counter !== 5'd0) begin
            bad++; $display("FAIL reset_counter got=%0d exp=0", counter);
        end
        total++;
        if (entries_out[0] !== {1'b1, 32'h0} || entries_out[3][DATA_W] !== 1'b0 || entries_out[6][DATA_W] !== 1'b0) begin
            bad++; $display("FAIL reset_entries e0=%h e3v=%b e6v=%b exp e0=100000000 v=0",
                            entries_out[0], entries_out[3][DATA_W], entries_out[6][DATA_W]);
        end
        advance();
    endtask

    task automatic test_fill();
        int p;
        p = 1;
        while (p < NUM_PRN) begin
            @(negedge clock);
            clear_inputs();
            for (int i = 0; i < NUM_WR; i++)
                if (p < NUM_PRN) begin
                    write_data[i] = mkw($urandom, p);
                    p++;
                end
            #1; advance();
        end
        @(negedge clock);
        clear_inputs();
        write_data[NUM_WR-1] = mkw(32'hFFFF_FFFF, 0);
        #1;
        total++;
        if (output_value[0] !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL fill_prn0_bypass got=%h exp=%h", output_value[0], {1'b1, 32'h0});
        end
        advance();
        @(posedge clock); #2;
        total++;
        if (counter !== 5'(NUM_PRN - 1)) begin
            bad++; $display("FAIL fill_counter got=%0d exp=%0d", counter, NUM_PRN - 1);
        end
        total++;
        if (entries_out[0] !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL fill_prn0 got=%h exp=%h", entries_out[0], {1'b1, 32'h0});
        end
    endtask

    task automatic test_invalidate();
        @(negedge clock);
        clear_inputs();
        prn_invalid[0] = 5'd5;
        prn_invalid[1] = 5'd5;
        prn_invalid[2] = 5'd0;
        read_prn[0]    = 5'd5;
        #1;
        total++;
        if (output_value[0][DATA_W] !== 1'b1) begin
            bad++; $display("FAIL inv_no_bypass got_valid=%b exp=1", output_value[0][DATA_W]);
        end
        advance();
        @(posedge clock); #2;
        total++;
        if (entries_out[5][DATA_W] !== 1'b0 || entries_out[0] !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL inv_entries e5v=%b e0=%h exp e5v=0 e0=100000000", entries_out[5][DATA_W], entries_out[0]);
        end
        total++;
        if (counter !== 5'(NUM_PRN - 2)) begin
            bad++; $display("FAIL inv_counter got=%0d exp=%0d", counter, NUM_PRN - 2);
        end
    endtask

    task automatic test_conflict();
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                @(negedge clock);
                clear_inputs();
                prn_invalid[2] = 5'd7;
                #1; advance();
            end
            @(negedge clock);
            clear_inputs();
            write_data[0]        = mkw(32'h0000_AAAA, 7);
            write_data[NUM_WR-1] = mkw(32'h0000_5555, 7);
            prn_invalid[0]       = 5'd7;
            read_prn[1]          = 5'd7;
            #1;
            total++;
            if (output_value[1] !== {1'b1, 32'h0000_5555}) begin
                bad++; $display("FAIL conflict_bypass r=%0d got=%h exp=%h", r, output_value[1], {1'b1, 32'h0000_5555});
            end
            advance();
            @(posedge clock); #2;
            total++;
            if (entries_out[7] !== {1'b1, 32'h0000_5555}) begin
                bad++; $display("FAIL conflict_entry r=%0d got=%h exp=%h", r, entries_out[7], {1'b1, 32'h0000_5555});
            end
            // Round 0: PRN 7 already valid, no change (30). Round 1: was invalid (29), +1 -> 30.
            total++;
            if (counter !== 5'(NUM_PRN - 2)) begin
                bad++; $display("FAIL conflict_counter r=%0d got=%0d exp=%0d", r, counter, NUM_PRN - 2);
            end
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] old9;
        old9 = m_value[9];
        @(negedge clock);
        clear_inputs();
        write_data[0] = mkw(32'hDEAD_BEEF, 9);
        read_prn[0]   = 5'd9;
        #1;
        total++;
        if (output_value[0] !== {1'b1, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", output_value[0], {1'b1, 32'hDEAD_BEEF});
        end
        total++;
        if (ov_nb[0] !== {1'b1, old9}) begin
            bad++; $display("FAIL nobypass_old got=%h exp=%h", ov_nb[0], {1'b1, old9});
        end
        advance();
        @(negedge clock);
        clear_inputs();
        read_prn[0] = 5'd9;
        #1;
        total++;
        if (ov_nb[0] !== {1'b1, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL nobypass_next got=%h exp=%h", ov_nb[0], {1'b1, 32'hDEAD_BEEF});
        end
        advance();
    endtask

    task automatic test_soak();
        logic [DATA_W:0] e;
        bit kn;
        int rb_fail;
        rb_fail = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clock);
            clear_inputs();
            for (int i = 0; i < NUM_WR; i++)
                if ($urandom_range(0, 3) != 0)
                    write_data[i] = mkw($urandom, int'($urandom_range(0, NUM_PRN - 1)));
            for (int j = 0; j < NUM_INV; j++)
                if ($urandom_range(0, 2) == 0)
                    prn_invalid[j] = 5'($urandom_range(0, NUM_PRN - 1));
            for (int k = 0; k < NUM_RD; k++)
                read_prn[k] = 5'($urandom_range(0, NUM_PRN - 1));
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                e  = exp_read(read_prn[k], 1'b1);
                kn = exp_known(read_prn[k], 1'b1);
                total++;
                if (output_value[k][DATA_W] !== e[DATA_W] ||
                    (kn && output_value[k][DATA_W-1:0] !== e[DATA_W-1:0])) begin
                    bad++;
                    if (rb_fail < 10)
                        $display("FAIL soak_read_bypass cyc=%0d k=%0d prn=%0d got=%h exp=%h", cyc, k, read_prn[k], output_value[k], e);
                    rb_fail++;
                end
                e  = exp_read(read_prn[k], 1'b0);
                kn = exp_known(read_prn[k], 1'b0);
                total++;
                if (ov_nb[k][DATA_W] !== e[DATA_W] ||
                    (kn && ov_nb[k][DATA_W-1:0] !== e[DATA_W-1:0])) begin
                    bad++;
                    if (rb_fail < 10)
                        $display("FAIL soak_read_reg cyc=%0d k=%0d prn=%0d got=%h exp=%h", cyc, k, read_prn[k], ov_nb[k], e);
                    rb_fail++;
                end
            end
            advance();
        end
        @(negedge clock);
        clear_inputs();
        #1; advance();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_invalidate();
        test_conflict();
        test_bypass();
        test_soak();
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clock);
        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_drain left=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
